// File: rtl/demux_dist_if.sv
// Handshake bundle between a symbol source/lane consumers and demux_dist.
// master drives symbols and acks; slave (the demux) drives ready, lanes, err, drop_cnt.
interface demux_dist_if #(
  parameter int NLANES = 31,
  parameter int DW     = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           sel;
  logic [DW-1:0]        inp;
  logic [NLANES*DW-1:0] out_data;
  logic [NLANES-1:0]    out_valid;
  logic [NLANES-1:0]    out_ack;
  logic                 err;
  logic [7:0]           drop_cnt;

  modport master (
    output in_valid, sel, inp, out_ack,
    input  in_ready, out_data, out_valid, err, drop_cnt
  );

  modport slave (
    input  in_valid, sel, inp, out_ack,
    output in_ready, out_data, out_valid, err, drop_cnt
  );
endinterface

// File: rtl/demux_dist.sv
// 1-to-31 symbol demux: each lane is a one-entry holding register with a full flag.
// Ports: clk, reset (async high), bus (slave side: in_*, sel, out_*, err, drop_cnt).
module demux_dist #(
  parameter int NLANES = 31,
  parameter int DW     = 2
) (
  input logic         clk,
  input logic         reset,
  demux_dist_if.slave bus
);

  logic [NLANES-1:0]    full;
  logic [NLANES*DW-1:0] data;
  logic                 err_q;
  logic [7:0]           cnt;

  logic                 inv;
  logic                 rdy;
  logic                 xfer;
  logic [NLANES-1:0]    load;

  assign inv = (bus.sel == 5'h1f);

  // Ready comes only from state and inputs; a full lane frees up
  // in the same cycle its consumer acks.
  always_comb begin
    rdy = 1'b1;
    if (!inv) rdy = !full[bus.sel] | bus.out_ack[bus.sel];
  end

  assign xfer = bus.in_valid & rdy;

  always_comb begin
    load = '0;
    if (xfer && !inv) load[bus.sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full  <= '0;
      data  <= '0;
      err_q <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      // A load wins over an ack on the same lane: no bubble.
      full  <= load | (full & ~bus.out_ack);
      for (int i = 0; i < NLANES; i++) begin
        if (load[i]) data[i*DW +: DW] <= bus.inp;
      end
      err_q <= xfer & inv;
      if (xfer && inv && cnt != 8'hff) cnt <= cnt + 8'd1;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = full;
  assign bus.out_data  = data;
  assign bus.err       = err_q;
  assign bus.drop_cnt  = cnt;

endmodule

// File: tb/tb_demux_dist.sv
// Directed self-checking bench for demux_dist.
// Vector table for single-cycle behaviour plus hand sequences for long cases.
module tb_demux_dist;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  demux_dist_if #(.NLANES(31), .DW(2)) bus ();

  demux_dist #(.NLANES(31), .DW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        v;
    logic [4:0]  s;
    logic [1:0]  d;
    logic [30:0] ack;
    logic        rdy;
    logic [30:0] ov;
    int          lane;
    logic [1:0]  ld;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic drive(input logic v, input logic [4:0] s,
                       input logic [1:0] d, input logic [30:0] ack);
    bus.in_valid = v;
    bus.sel      = s;
    bus.inp      = d;
    bus.out_ack  = ack;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd0, 2'd0, '0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    drive(1'b0, 5'd0, 2'd0, '0);

    tbl[0]  = '{1'b1, 5'd12, 2'd2, 31'h0,        1'b1, 31'h1000,      12, 2'd2, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 5'd30, 2'd1, 31'h0,        1'b1, 31'h4000_1000, 30, 2'd1, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 5'd0,  2'd0, 31'h4000_0000, 1'b1, 31'h1000,     30, 2'd1, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 5'd31, 2'd3, 31'h0,        1'b1, 31'h1000,      12, 2'd2, 1'b1, 8'd1};
    tbl[4]  = '{1'b1, 5'd5,  2'd1, 31'h0,        1'b1, 31'h1020,       5, 2'd1, 1'b0, 8'd1};
    tbl[5]  = '{1'b1, 5'd5,  2'd2, 31'h0,        1'b0, 31'h1020,       5, 2'd1, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 5'd5,  2'd2, 31'h20,       1'b1, 31'h1020,       5, 2'd2, 1'b0, 8'd1};
    tbl[7]  = '{1'b0, 5'd0,  2'd0, 31'h1020,     1'b1, 31'h0,          5, 2'd2, 1'b0, 8'd1};
    tbl[8]  = '{1'b0, 5'd0,  2'd0, 31'h20,       1'b1, 31'h0,         12, 2'd2, 1'b0, 8'd1};
    tbl[9]  = '{1'b1, 5'd0,  2'd3, 31'h1,        1'b1, 31'h1,          0, 2'd3, 1'b0, 8'd1};
    tbl[10] = '{1'b1, 5'd31, 2'd0, 31'h0,        1'b1, 31'h1,          0, 2'd3, 1'b1, 8'd2};
    tbl[11] = '{1'b1, 5'd31, 2'd1, 31'h0,        1'b1, 31'h1,          0, 2'd3, 1'b1, 8'd3};
    tbl[12] = '{1'b0, 5'd31, 2'd0, 31'h0,        1'b1, 31'h1,          0, 2'd3, 1'b0, 8'd3};

    // reset state
    @(posedge clk);
    #1;
    chk("rst_ov",   64'(bus.out_valid), 64'd0);
    chk("rst_data", 64'(bus.out_data),  64'd0);
    chk("rst_err",  64'(bus.err),       64'd0);
    chk("rst_cnt",  64'(bus.drop_cnt),  64'd0);
    chk("rst_rdy",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    reset = 1'b0;

    // vector table
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ack);
      #1;
      chk($sformatf("v%0d_rdy", i), 64'(bus.in_ready), 64'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ov", i), 64'(bus.out_valid), 64'(tbl[i].ov));
      chk($sformatf("v%0d_lane", i),
          64'(bus.out_data[tbl[i].lane*2 +: 2]), 64'(tbl[i].ld));
      chk($sformatf("v%0d_err", i), 64'(bus.err), 64'(tbl[i].err));
      chk($sformatf("v%0d_cnt", i), 64'(bus.drop_cnt), 64'(tbl[i].cnt));
    end

    // first-transfer scenario: only lane 12 populated
    do_reset();
    drive(1'b1, 5'd12, 2'b10, '0);
    @(posedge clk);
    #1;
    chk("l12_ov",   64'(bus.out_valid), 64'h1000);
    chk("l12_data", 64'(bus.out_data),  64'h200_0000);

    // 300 back-to-back invalid-sel drops
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i > 0) @(negedge clk);
      drive(1'b1, 5'd31, 2'd3, '0);
      #1;
      chk("drop_rdy", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      chk("drop_err", 64'(bus.err), 64'd1);
      chk("drop_cnt", 64'(bus.drop_cnt), 64'((i + 1 > 255) ? 255 : i + 1));
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 2'd0, '0);
    @(posedge clk);
    #1;
    chk("drop_err_end", 64'(bus.err),       64'd0);
    chk("drop_cnt_sat", 64'(bus.drop_cnt),  64'd255);
    chk("drop_ov",      64'(bus.out_valid), 64'd0);

    // two sweeps without acks
    do_reset();
    for (int s = 0; s < 31; s++) begin
      if (s > 0) @(negedge clk);
      drive(1'b1, 5'(s), 2'(s), '0);
      #1;
      chk($sformatf("sw1_rdy%0d", s), 64'(bus.in_ready), 64'd1);
      @(posedge clk);
    end
    #1;
    chk("sw1_ov", 64'(bus.out_valid), 64'h7fff_ffff);
    for (int s = 0; s < 31; s++)
      chk($sformatf("sw1_lane%0d", s), 64'(bus.out_data[s*2 +: 2]), 64'(s % 4));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 5'd0, 2'd3, '0);
      #1;
      chk("sw2_stall_rdy", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("sw2_lane0", 64'(bus.out_data[1:0]), 64'd0);
      chk("sw2_ov",    64'(bus.out_valid),     64'h7fff_ffff);
    end

    // async reset mid-sweep with lanes 0..9 full and some drops counted
    do_reset();
    for (int s = 0; s < 12; s++) begin
      if (s > 0) @(negedge clk);
      if (s < 2) drive(1'b1, 5'd31, 2'd0, '0);
      else drive(1'b1, 5'(s - 2), 2'(s + 1), '0);
      @(posedge clk);
    end
    #1;
    chk("pre_ov",  64'(bus.out_valid), 64'h3ff);
    chk("pre_cnt", 64'(bus.drop_cnt),  64'd2);
    drive(1'b1, 5'd5, 2'd1, '0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ov",   64'(bus.out_valid), 64'd0);
    chk("arst_data", 64'(bus.out_data),  64'd0);
    chk("arst_cnt",  64'(bus.drop_cnt),  64'd0);
    chk("arst_rdy",  64'(bus.in_ready),  64'd1);
    @(posedge clk);
    #1;
    chk("in_rst_ov", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    drive(1'b1, 5'd31, 2'd0, '0);
    @(posedge clk);
    #1;
    chk("in_rst_cnt", 64'(bus.drop_cnt), 64'd0);
    chk("in_rst_err", 64'(bus.err),      64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 5'd3, 2'd2, '0);
    @(posedge clk);
    #1;
    chk("post_rst_ov",   64'(bus.out_valid),    64'h8);
    chk("post_rst_lane", 64'(bus.out_data[7:6]), 64'd2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
